sequenceur_mux_1x8: RTL and testbench

Parallel-to-serial sequencer that drives the 8:1 `multiplexeur_1x8`. It accepts one 8-bit word per valid/ready handshake, holds the word on the mux data inputs, and sweeps the 3-bit select from 0 to 7. The mux output is presented as a serial bit stream with its own valid/ready handshake. It sits directly upstream of the mux and owns all select sequencing, so the mux stays purely combinational.

---
 rtl/seq_mux_pkg.sv | 23 ++
 rtl/multiplexeur_1x8.sv | 33 +++
 rtl/sequenceur_mux_1x8.sv | 147 ++++++++++++++
 tb/tb_sequenceur_mux_1x8.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mux_pkg.sv
// Shared types and constants for the sequenceur_mux_1x8 slice.
// Imported by the 8:1 mux and by the sequencer top.
package seq_mux_pkg;

  localparam int SEL_W  = 3;
  localparam int WORD_W = 8;

  localparam logic [SEL_W-1:0] SEL_LAST = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PARITY,
    ST_GAP
  } state_t;

  function automatic logic even_par(
    input logic [WORD_W-1:0] w
  );
    return ^w;
  endfunction

endpackage

// File: rtl/multiplexeur_1x8.sv
// Purely combinational 8:1 bit multiplexer.
// Input a is selected by s0=0, through h selected by s0=7.
module multiplexeur_1x8
  import seq_mux_pkg::*;
(
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             e,
  input  logic             f,
  input  logic             g,
  input  logic             h,
  input  logic [SEL_W-1:0] s0,
  output logic             s
);

  always_comb begin
    s = 1'b0;
    unique case (s0)
      3'd0: s = a;
      3'd1: s = b;
      3'd2: s = c;
      3'd3: s = d;
      3'd4: s = e;
      3'd5: s = f;
      3'd6: s = g;
      3'd7: s = h;
      default: s = 1'b0;
    endcase
  end

endmodule

// File: rtl/sequenceur_mux_1x8.sv
// Parallel-to-serial sequencer sweeping the select of multiplexeur_1x8.
// Optional parity beat: define SEQ_MUX_PARITY_EN.
module sequenceur_mux_1x8
  import seq_mux_pkg::*;
#(
  parameter int unsigned GAP = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_first,
  output logic              out_last,
  output logic [SEL_W-1:0]  sel
);

  localparam logic [3:0] GAP_LAST =
    4'((GAP > 0) ? GAP - 1 : 0);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [WORD_W-1:0] word_q;
  logic [3:0]        cnt_q, cnt_d;
  logic              load;
  logic              ready_q;
  logic              valid_q;
  logic              first_q;
  logic              last_q;
  logic              last_d;
  logic              beat_done;
  logic              mux_s;

  assign beat_done = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && ready_q) begin
          load    = 1'b1;
          sel_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (beat_done) begin
          if (sel_q != SEL_LAST) begin
            sel_d = sel_q + 3'd1;
          end else begin
            cnt_d = '0;
`ifdef SEQ_MUX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
`endif
          end
        end
      end
      ST_PARITY: begin
`ifdef SEQ_MUX_PARITY_EN
        if (beat_done) begin
          cnt_d   = '0;
          state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef SEQ_MUX_PARITY_EN
  assign last_d = (state_d == ST_PARITY);
`else
  assign last_d = (state_d == ST_SHIFT) &&
                  (sel_d == SEL_LAST);
`endif

  // Handshake flags are computed from next state so they register cleanly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      if (load) begin
        word_q <= in_data;
      end
      ready_q <= (state_d == ST_IDLE);
      valid_q <= (state_d == ST_SHIFT) ||
                 (state_d == ST_PARITY);
      first_q <= (state_d == ST_SHIFT) &&
                 (sel_d == '0);
      last_q  <= last_d;
    end
  end

  multiplexeur_1x8 u_mux (
    .a  (word_q[0]),
    .b  (word_q[1]),
    .c  (word_q[2]),
    .d  (word_q[3]),
    .e  (word_q[4]),
    .f  (word_q[5]),
    .g  (word_q[6]),
    .h  (word_q[7]),
    .s0 (sel_q),
    .s  (mux_s)
  );

`ifdef SEQ_MUX_PARITY_EN
  assign out_bit = (state_q == ST_PARITY) ?
                   even_par(word_q) : mux_s;
`else
  assign out_bit = mux_s;
`endif

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_first = first_q;
  assign out_last  = last_q;
  assign sel       = sel_q;

endmodule

// File: tb/tb_sequenceur_mux_1x8.sv
// Scoreboard bench for sequenceur_mux_1x8 (GAP=2).
// Builds with or without SEQ_MUX_PARITY_EN.
module tb_sequenceur_mux_1x8;

  localparam int GAP_P = 2;
`ifdef SEQ_MUX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct packed {
    logic       b;
    logic       f;
    logic       l;
    logic       cs;
    logic [2:0] s;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_bit;
  logic       out_first;
  logic       out_last;
  logic [2:0] sel;

  int    n_pass = 0;
  int    n_total = 0;
  beat_t q[$];
  bit    rnd = 1'b0;
  bit    stall_req = 1'b0;
  bit    first_pend = 1'b0;
  int    gap_k = 0;

  sequenceur_mux_1x8 #(.GAP(GAP_P)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_first (out_first),
    .out_last  (out_last),
    .sel       (sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    else
      n_pass++;
  endtask

  // Reference: bit k of the word is (d >> k) & 1, parity is popcount mod 2.
  task automatic push_word(input logic [7:0] d);
    beat_t e;
    int    ones = 0;
    for (int k = 0; k < 8; k++) begin
      e.b  = 1'((d >> k) & 1);
      e.f  = (k == 0);
      e.l  = (k == 7) && !PAR;
      e.cs = 1'b1;
      e.s  = 3'(k);
      ones += int'(e.b);
      q.push_back(e);
    end
    if (PAR) begin
      e.b  = 1'(ones % 2);
      e.f  = 1'b0;
      e.l  = 1'b1;
      e.cs = 1'b0;
      e.s  = 3'd0;
      q.push_back(e);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_req)
        out_ready = 1'b0;
      else if (rnd)
        out_ready = ($urandom_range(3) != 0);
      else
        out_ready = 1'b1;
    end
  end

  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        first_pend = 1'b0;
        gap_k = 0;
      end else begin
        chk("no_overlap", 32'(in_ready & out_valid), 0);
        if (first_pend) begin
          chk("first_latency",
              {30'd0, out_valid, out_first}, 3);
          first_pend = 1'b0;
        end
        if (gap_k > 0) begin
          gap_k--;
          if (gap_k > 0)
            chk("gap_idle",
                {30'd0, in_ready, out_valid}, 0);
          else
            chk("gap_ready", 32'(in_ready), 1);
        end
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = q[0];
            chk("beat_bit", 32'(out_bit), 32'(e.b));
            chk("beat_first", 32'(out_first), 32'(e.f));
            chk("beat_last", 32'(out_last), 32'(e.l));
            if (e.cs)
              chk("beat_sel", 32'(sel), 32'(e.s));
            if (out_ready) begin
              void'(q.pop_front());
              if (e.l) gap_k = GAP_P + 1;
            end
          end
        end
        if (in_valid && in_ready) begin
          push_word(in_data);
          first_pend = 1'b1;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d,
                      input bit keep);
    int n = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_sel(input logic [2:0] s);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && sel == s) && n < 200);
    chk("sel_reached", 32'(out_valid && sel == s), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(q.size() == 0 && in_ready &&
                 gap_k == 0) && n < 400);
    chk("drain", 32'(q.size() == 0 && in_ready), 1);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    repeat (3) begin
      @(negedge clk);
      chk("reset_outs",
          {25'd0, in_ready, out_valid, out_first,
           out_last, sel}, 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_before_edge", 32'(in_ready), 0);
    @(negedge clk);
    chk("ready_after_reset", 32'(in_ready), 1);
    repeat (2) begin
      @(negedge clk);
      chk("idle_no_valid", 32'(out_valid), 0);
    end

    send(8'hA5, 1'b0);
    wait_idle();
    send(8'h07, 1'b0);
    wait_idle();

    send(8'hF0, 1'b0);
    wait_sel(3'd1);
    stall_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_sel", 32'(sel), 2);
      chk("stall_bit", 32'(out_bit), 0);
      chk("stall_valid", 32'(out_valid), 1);
    end
    stall_req = 1'b0;
    wait_idle();

    send(8'h01, 1'b1);
    send(8'h80, 1'b0);
    wait_idle();

    send(8'hFF, 1'b0);
    wait_sel(3'd4);
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", 32'(out_valid), 0);
    chk("async_last", 32'(out_last), 0);
    chk("async_sel", 32'(sel), 0);
    q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(8'h3C, 1'b0);
    wait_idle();

    rnd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(8'($urandom), 1'b0);
      repeat ($urandom_range(2)) @(posedge clk);
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
